// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the write port of one sync_fifo among NUM_REQ
// producers; a grant lasts until req_last or MAX_BURST accepted beats.
module sync_fifo_wr_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  MAX_BURST  = 4,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W      = $clog2(MAX_BURST) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_full,
    output logic                          grant_valid,
    output logic [ID_W-1:0]               grant_id,
    output logic                          burst_done
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state;
    logic [ID_W-1:0]         rr_ptr;
    logic [CNT_W-1:0]        beat_cnt;
    logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];
    logic                    pick_found;
    logic [ID_W-1:0]         pick_id;
    logic                    accept;
    logic                    last_beat;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search upward from rr_ptr with an explicit wrap so non-power-of-2 counts
    // never produce an out-of-range index.
    always_comb begin : rr_search
        int              idx;
        logic [ID_W-1:0] idx_w;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        idx        = 0;
        idx_w      = '0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_w = ID_W'(idx);
            if (!pick_found && req_valid[idx_w]) begin
                pick_found = 1'b1;
                pick_id    = idx_w;
            end
        end
    end

    assign accept    = !rst && (state == BURST) && !fifo_full && req_valid[grant_id];
    assign last_beat = req_last[grant_id] || (beat_cnt == CNT_W'(MAX_BURST - 1));

    always_comb begin : ready_decode
        req_ready = '0;
        if (!rst && (state == BURST) && !fifo_full) req_ready[grant_id] = 1'b1;
    end

    assign fifo_wr_en  = accept;
    assign fifo_din    = data_arr[grant_id];
    assign grant_valid = !rst && (state == BURST);
    assign burst_done  = accept && last_beat;

    // NOTE: non-blocking assignments let every register update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_id;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Bench for sync_fifo_wr_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a packet-level reference model.
`timescale 1ns/1ps
module tb_sync_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              fifo_wr_en;
    logic [DW-1:0]     fifo_din;
    logic              fifo_full = 1'b0;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic              burst_done;

    sync_fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .fifo_full(fifo_full), .grant_valid(grant_valid),
        .grant_id(grant_id), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Per-requester pending beats, {last, data}; the front is what the source presents.
    logic [8:0] src_q [NR][$];
    logic [7:0] cur_d [NR];
    bit         gate [NR];

    // Reference model: one open grant at a time, beats counted per burst.
    bit         m_busy = 1'b0;
    logic [1:0] m_owner = '0;
    logic [1:0] m_next = '0;
    int         m_count = 0;

    bit         rand_full = 1'b0;
    bit         rand_gate = 1'b0;
    bit         full_force = 1'b0;
    bit         prev_gv = 1'b0;

    logic [7:0] act_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] want[$];
    logic [1:0] act_g[$];
    logic [1:0] want_g[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit sources_pending();
        for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_inputs();
        fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : full_force;
        for (int i = 0; i < NR; i++) begin
            gate[i] = rand_gate && !(m_busy && m_owner == 2'(i)) && ($urandom_range(0, 3) == 0);
            if (src_q[i].size() != 0) begin
                req_valid[i]           = !gate[i];
                req_last[i]            = src_q[i][0][8];
                cur_d[i]               = src_q[i][0][7:0];
                req_data[i*DW +: DW]   = src_q[i][0][7:0];
            end else begin
                req_valid[i]           = 1'b0;
                req_last[i]            = 1'b0;
                cur_d[i]               = 8'h00;
                req_data[i*DW +: DW]   = 8'h00;
            end
        end
    endtask

    // One clock: drive, check outputs at negedge, advance the model at posedge.
    task automatic cycle();
        logic [NR-1:0] e_ready;
        bit            e_wr, e_done, e_gv, found;
        logic [1:0]    id;
        drive_inputs();
        @(negedge clk);
        e_ready = '0; e_wr = 1'b0; e_done = 1'b0; e_gv = 1'b0;
        if (!rst) begin
            e_gv    = m_busy;
            e_ready = (m_busy && !fifo_full) ? (4'b0001 << m_owner) : 4'b0000;
            e_wr    = m_busy && !fifo_full && req_valid[m_owner];
            e_done  = e_wr && (req_last[m_owner] || (m_count + 1 == MB));
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
        chk("grant_valid", 32'(grant_valid), 32'(e_gv));
        chk("burst_done", 32'(burst_done), 32'(e_done));
        if (!rst) chk("grant_id", 32'(grant_id), 32'(m_owner));
        if (e_wr) begin
            chk("fifo_din", 32'(fifo_din), 32'(cur_d[m_owner]));
            exp_q.push_back(cur_d[m_owner]);
        end
        if (fifo_wr_en) act_q.push_back(fifo_din);
        if (grant_valid && !prev_gv) act_g.push_back(grant_id);
        prev_gv = grant_valid;
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0; m_next = '0; m_owner = '0; m_count = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                id = 2'((int'(m_next) + k) % NR);
                if (!found && req_valid[id]) begin
                    found = 1'b1; m_owner = id;
                end
            end
            if (found) begin m_busy = 1'b1; m_count = 0; end
        end else if (e_wr) begin
            void'(src_q[m_owner].pop_front());
            m_count++;
            if (e_done) begin
                m_busy = 1'b0;
                m_next = 2'((int'(m_owner) + 1) % NR);
            end
        end
        #1;
    endtask

    task automatic drain(string tag, int budget);
        int n = 0;
        while (sources_pending() && n < budget) begin cycle(); n++; end
        chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
        cycle();
        cycle();
    endtask

    task automatic wait_writes(string tag, int cnt);
        int n = 0;
        while (act_q.size() < cnt && n < 50) begin cycle(); n++; end
        chk({tag, "_timeout"}, 32'(n < 50), 32'd1);
    endtask

    task automatic check_writes(string tag);
        chk({tag, "_count"}, 32'(act_q.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < act_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 32'(act_q[i]), 32'(want[i]));
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic check_grants(string tag);
        chk({tag, "_ngrant"}, 32'(act_g.size()), 32'(want_g.size()));
        for (int i = 0; i < want_g.size() && i < act_g.size(); i++)
            chk($sformatf("%s_g%0d", tag, i), 32'(act_g[i]), 32'(want_g[i]));
        act_g.delete();
    endtask

    task automatic load_random(output int total);
        total = 0;
        for (int i = 0; i < NR; i++) begin
            int npk;
            npk = $urandom_range(1, 3);
            for (int p = 0; p < npk; p++) begin
                int len;
                bit close;
                len   = $urandom_range(1, 6);
                close = (p == npk - 1) || ($urandom_range(0, 1) == 1);
                for (int b = 0; b < len; b++) begin
                    src_q[i].push_back({(b == len - 1) && close, 8'($urandom)});
                    total++;
                end
            end
        end
    endtask

    initial begin
        int total;

        // Reset held two cycles with every requester valid; round-robin follows.
        src_q[0].push_back({1'b1, 8'h00});
        src_q[0].push_back({1'b1, 8'h00});
        src_q[1].push_back({1'b1, 8'h11});
        src_q[2].push_back({1'b1, 8'h22});
        src_q[3].push_back({1'b1, 8'h33});
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        drain("rr", 100);
        want   = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        want_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        check_writes("rr");
        check_grants("rr");

        // Single requester, three-beat packet.
        src_q[1].push_back({1'b0, 8'hA1});
        src_q[1].push_back({1'b0, 8'hA2});
        src_q[1].push_back({1'b1, 8'hA3});
        drain("single", 50);
        want   = '{8'hA1, 8'hA2, 8'hA3};
        want_g = '{2'd1};
        check_writes("single");
        check_grants("single");

        // MAX_BURST cap splits six unterminated beats into 4 + 2.
        for (int b = 0; b < 6; b++) src_q[2].push_back({1'b0, 8'(8'h10 + b)});
        drain("cap", 50);
        want   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        want_g = '{2'd2, 2'd2};
        check_writes("cap");
        check_grants("cap");
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Backpressure for three cycles in the middle of a req0 burst.
        for (int b = 0; b < 4; b++) src_q[0].push_back({b == 3, 8'(8'hB0 + b)});
        wait_writes("bp", 2);
        full_force = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("bp_ready0", 32'(req_ready[0]), 32'd0);
        end
        chk("bp_no_write", 32'(act_q.size()), 32'd2);
        full_force = 1'b0;
        drain("bp", 50);
        want   = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        want_g = '{2'd0};
        check_writes("bp");
        check_grants("bp");

        // Reset after two beats of req3: the next grant restarts at req0.
        for (int b = 0; b < 4; b++) src_q[3].push_back({1'b0, 8'(8'hC0 + b)});
        src_q[0].push_back({1'b1, 8'hD0});
        wait_writes("rstmid", 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drain("rstmid", 50);
        want   = '{8'hC0, 8'hC1, 8'hD0, 8'hC2, 8'hC3};
        want_g = '{2'd3, 2'd0, 2'd3};
        check_writes("rstmid");
        check_grants("rstmid");

        // Randomized traffic with random fullness and non-grantee valid gating.
        for (int r = 0; r < 4; r++) begin
            rst = 1'b1;
            cycle();
            rst = 1'b0;
            act_q.delete();
            exp_q.delete();
            act_g.delete();
            load_random(total);
            rand_full = 1'b1;
            rand_gate = 1'b1;
            drain($sformatf("rand%0d", r), 2000);
            rand_full = 1'b0;
            rand_gate = 1'b0;
            chk($sformatf("rand%0d_total", r), 32'(act_q.size()), 32'(total));
            want = exp_q;
            check_writes($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
